// File: rtl/button_event_classifier_pkg.sv
// Shared definitions for the button event classifier: FSM state encodings,
// simulation thresholds and a threshold selection helper.
package button_event_classifier_pkg;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    PRESS1       = 3'd1,
    WAIT_GAP     = 3'd2,
    LONG_HOLD    = 3'd3,
    WAIT_RELEASE = 3'd4
  } state_t;

  localparam int SIM_LONG = 200;
  localparam int SIM_GAP  = 50;

  // Short simulation thresholds replace the real-time ones when sim is set.
  function automatic int pickThreshold(input int sim, input int simValue, input int realValue);
    return (sim != 0) ? simValue : realValue;
  endfunction

endpackage

// File: rtl/button_event_classifier_if.sv
// Button level in, classified event pulses, held level and event count out.
interface button_event_classifier_if;

  logic       ButtonIn;
  logic       ShortPress;
  logic       LongPress;
  logic       DoubleClick;
  logic       Held;
  logic [7:0] EventCount;

  modport master (
    output ButtonIn,
    input  ShortPress, LongPress, DoubleClick, Held, EventCount
  );

  modport slave (
    input  ButtonIn,
    output ShortPress, LongPress, DoubleClick, Held, EventCount
  );

endinterface

// File: rtl/button_event_classifier_event_counter.sv
// 8-bit wrapping event counter with increment enable, shared with the display path.
module event_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  output logic [7:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= 8'd0;
    end else if (inc) begin
      count <= count + 8'd1;
    end
  end

endmodule

// File: rtl/button_event_classifier.sv
// Classifies debounced button gestures into short press, long press or double
// click pulses, with a held level and a wrapping event counter.
module button_event_classifier
  import button_event_classifier_pkg::*;
#(
  parameter int sim         = 0,
  parameter int LONG_CYCLES = 50_000_000,
  parameter int GAP_CYCLES  = 12_500_000,
  parameter int CNT_W       = 26
) (
  input  logic                      clk,
  input  logic                      reset,
  button_event_classifier_if.slave  bus
);

  localparam int L = pickThreshold(sim, SIM_LONG, LONG_CYCLES);
  localparam int G = pickThreshold(sim, SIM_GAP, GAP_CYCLES);
  localparam logic [CNT_W-1:0] L_LAST = CNT_W'(L - 1);
  localparam logic [CNT_W-1:0] G_LAST = CNT_W'(G - 1);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             shortPulse;
  logic             longPulse;
  logic             doublePulse;
  logic             heldLevel;
  logic             longHit;
  logic             secondRise;
  logic             gapExpire;
  logic             fire;
  logic [7:0]       eventCount;

  // Event conditions feed both the FSM and the counter so EventCount moves on
  // the same edge that raises the pulse.
  always_comb begin
    longHit    = (state == PRESS1) && bus.ButtonIn && (count == L_LAST);
    secondRise = (state == WAIT_GAP) && bus.ButtonIn;
    gapExpire  = (state == WAIT_GAP) && !bus.ButtonIn && (count == G_LAST);
    fire       = longHit || secondRise || gapExpire;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      count       <= '0;
      shortPulse  <= 1'b0;
      longPulse   <= 1'b0;
      doublePulse <= 1'b0;
      heldLevel   <= 1'b0;
    end else begin
      shortPulse  <= gapExpire;
      longPulse   <= longHit;
      doublePulse <= secondRise;
      case (state)
        IDLE: begin
          if (bus.ButtonIn) begin
            state <= PRESS1;
            count <= ONE;
          end
        end
        PRESS1: begin
          if (!bus.ButtonIn) begin
            state <= WAIT_GAP;
            count <= ONE;
          end else if (longHit) begin
            state     <= LONG_HOLD;
            heldLevel <= 1'b1;
          end else begin
            count <= count + ONE;
          end
        end
        WAIT_GAP: begin
          if (bus.ButtonIn) begin
            state <= WAIT_RELEASE;
          end else if (gapExpire) begin
            state <= IDLE;
          end else begin
            count <= count + ONE;
          end
        end
        LONG_HOLD: begin
          if (!bus.ButtonIn) begin
            state     <= IDLE;
            heldLevel <= 1'b0;
          end
        end
        WAIT_RELEASE: begin
          if (!bus.ButtonIn) begin
            state <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          heldLevel <= 1'b0;
        end
      endcase
    end
  end

  event_counter u_event_counter (
    .clk   (clk),
    .reset (reset),
    .inc   (fire),
    .count (eventCount)
  );

  assign bus.ShortPress  = shortPulse;
  assign bus.LongPress   = longPulse;
  assign bus.DoubleClick = doublePulse;
  assign bus.Held        = heldLevel;
  assign bus.EventCount  = eventCount;

endmodule

// File: tb/tb_button_event_classifier.sv
// Directed bench for button_event_classifier with simulation thresholds
// (long press 200 cycles, double-click gap 50 cycles).
module tb_button_event_classifier;

  typedef struct {
    int hi;
    int gap;
    int hi2;
    int expShort;
    int expLong;
    int expDouble;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   failures;
  int   expCount;
  int   shortSeen;
  int   longSeen;
  int   doubleSeen;
  int   overlapSeen;
  vec_t vecs[10];

  button_event_classifier_if bus ();

  button_event_classifier #(.sim(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tally every pulse seen outside reset so gestures can be checked as a whole.
  always @(negedge clk) begin
    if (reset) begin
      shortSeen   += int'(bus.ShortPress);
      longSeen    += int'(bus.LongPress);
      doubleSeen  += int'(bus.DoubleClick);
      if ((int'(bus.ShortPress) + int'(bus.LongPress) + int'(bus.DoubleClick)) > 1)
        overlapSeen++;
    end
  end

  // Each call holds level b for n rising edges, starting and ending on a falling edge.
  task automatic applyStimulus(input logic b, input int n);
    for (int i = 0; i < n; i++) begin
      bus.ButtonIn = b;
      @(negedge clk);
    end
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic checkIdleOutputs(input string name);
    checkOutput({name, "_short"}, int'(bus.ShortPress), 0);
    checkOutput({name, "_long"}, int'(bus.LongPress), 0);
    checkOutput({name, "_double"}, int'(bus.DoubleClick), 0);
    checkOutput({name, "_held"}, int'(bus.Held), 0);
  endtask

  initial begin
    int s0, l0, d0;
    checks      = 0;
    failures    = 0;
    expCount    = 0;
    shortSeen   = 0;
    longSeen    = 0;
    doubleSeen  = 0;
    overlapSeen = 0;

    vecs[0] = '{hi: 100, gap: 60, hi2: 0,   expShort: 1, expLong: 0, expDouble: 0};
    vecs[1] = '{hi: 300, gap: 60, hi2: 0,   expShort: 0, expLong: 1, expDouble: 0};
    vecs[2] = '{hi: 20,  gap: 30, hi2: 20,  expShort: 0, expLong: 0, expDouble: 1};
    vecs[3] = '{hi: 20,  gap: 49, hi2: 20,  expShort: 0, expLong: 0, expDouble: 1};
    vecs[4] = '{hi: 20,  gap: 50, hi2: 20,  expShort: 2, expLong: 0, expDouble: 0};
    vecs[5] = '{hi: 199, gap: 60, hi2: 0,   expShort: 1, expLong: 0, expDouble: 0};
    vecs[6] = '{hi: 200, gap: 60, hi2: 0,   expShort: 0, expLong: 1, expDouble: 0};
    vecs[7] = '{hi: 10,  gap: 30, hi2: 250, expShort: 0, expLong: 0, expDouble: 1};
    vecs[8] = '{hi: 1,   gap: 1,  hi2: 1,   expShort: 0, expLong: 0, expDouble: 1};
    vecs[9] = '{hi: 1,   gap: 50, hi2: 0,   expShort: 1, expLong: 0, expDouble: 0};

    // Reset held with the button toggling.
    reset        = 1'b0;
    bus.ButtonIn = 1'b0;
    for (int i = 0; i < 11; i++) begin
      #1 bus.ButtonIn = ~bus.ButtonIn;
    end
    checkIdleOutputs("in_reset");
    checkOutput("in_reset_count", int'(bus.EventCount), 0);
    @(negedge clk);
    bus.ButtonIn = 1'b0;
    reset        = 1'b1;
    applyStimulus(1'b0, 3);
    checkIdleOutputs("after_reset");
    checkOutput("after_reset_count", int'(bus.EventCount), 0);

    // Short press: pulse on the 50th low sample after release.
    applyStimulus(1'b1, 100);
    applyStimulus(1'b0, 49);
    checkOutput("short_early", int'(bus.ShortPress), 0);
    applyStimulus(1'b0, 1);
    checkOutput("short_pulse", int'(bus.ShortPress), 1);
    expCount++;
    checkOutput("short_count", int'(bus.EventCount), expCount);
    applyStimulus(1'b0, 1);
    checkOutput("short_one_cycle", int'(bus.ShortPress), 0);
    applyStimulus(1'b0, 10);

    // Long press: pulse on the edge sampling the 200th high, Held until release.
    applyStimulus(1'b1, 199);
    checkOutput("long_early", int'(bus.LongPress), 0);
    checkOutput("held_early", int'(bus.Held), 0);
    applyStimulus(1'b1, 1);
    checkOutput("long_pulse", int'(bus.LongPress), 1);
    checkOutput("long_held", int'(bus.Held), 1);
    expCount++;
    checkOutput("long_count", int'(bus.EventCount), expCount);
    applyStimulus(1'b1, 1);
    checkOutput("long_one_cycle", int'(bus.LongPress), 0);
    applyStimulus(1'b1, 99);
    checkOutput("held_still", int'(bus.Held), 1);
    applyStimulus(1'b0, 1);
    checkOutput("held_released", int'(bus.Held), 0);
    s0 = shortSeen;
    applyStimulus(1'b0, 80);
    checkOutput("long_no_short", shortSeen - s0, 0);

    // Double click: pulse one edge after the second rise, nothing later.
    applyStimulus(1'b1, 20);
    applyStimulus(1'b0, 30);
    applyStimulus(1'b1, 1);
    checkOutput("double_pulse", int'(bus.DoubleClick), 1);
    expCount++;
    checkOutput("double_count", int'(bus.EventCount), expCount);
    s0 = shortSeen;
    applyStimulus(1'b1, 19);
    applyStimulus(1'b0, 80);
    checkOutput("double_no_short", shortSeen - s0, 0);
    checkOutput("double_count_after", int'(bus.EventCount), expCount);

    // Whole-gesture vectors.
    for (int v = 0; v < 10; v++) begin
      s0 = shortSeen;
      l0 = longSeen;
      d0 = doubleSeen;
      applyStimulus(1'b1, vecs[v].hi);
      applyStimulus(1'b0, vecs[v].gap);
      if (vecs[v].hi2 > 0) applyStimulus(1'b1, vecs[v].hi2);
      applyStimulus(1'b0, 60);
      expCount += vecs[v].expShort + vecs[v].expLong + vecs[v].expDouble;
      checkOutput($sformatf("vec%0d_short", v), shortSeen - s0, vecs[v].expShort);
      checkOutput($sformatf("vec%0d_long", v), longSeen - l0, vecs[v].expLong);
      checkOutput($sformatf("vec%0d_double", v), doubleSeen - d0, vecs[v].expDouble);
      checkOutput($sformatf("vec%0d_held", v), int'(bus.Held), 0);
      checkOutput($sformatf("vec%0d_count", v), int'(bus.EventCount), expCount & 255);
    end

    // Asynchronous reset while in LONG_HOLD.
    applyStimulus(1'b1, 250);
    expCount++;
    checkOutput("hold_before_reset", int'(bus.Held), 1);
    checkOutput("hold_count", int'(bus.EventCount), expCount & 255);
    #2 reset = 1'b0;
    #1;
    checkIdleOutputs("async_reset");
    checkOutput("async_reset_count", int'(bus.EventCount), 0);
    expCount = 0;
    @(negedge clk);
    bus.ButtonIn = 1'b0;
    reset        = 1'b1;
    applyStimulus(1'b0, 5);
    checkIdleOutputs("post_async_reset");

    // 256 short presses wrap the event counter back to zero.
    s0 = shortSeen;
    for (int p = 0; p < 255; p++) begin
      applyStimulus(1'b1, 5);
      applyStimulus(1'b0, 52);
    end
    checkOutput("count_255", int'(bus.EventCount), 255);
    applyStimulus(1'b1, 5);
    applyStimulus(1'b0, 52);
    checkOutput("count_wrap", int'(bus.EventCount), 0);
    checkOutput("wrap_shorts", shortSeen - s0, 256);

    checkOutput("no_overlap", overlapSeen, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
